// File: rtl/reset_sequencer.sv
// Reset generator for one clock domain. It asserts reset asynchronously and
// releases it only on a clock edge. After a minimum hold time it releases the
// staged domain resets one at a time, lowest index first.
// Ports:
//   clk      - domain clock
//   reset    - raw reset, asynchronous, active-high
//   sw_req   - synchronous software reset request (honoured in STRETCH_REL/RUN)
//   rst_sync - synchronized reset: asserts asynchronously, deasserts synchronously
//   rst_out  - staged domain resets, active-high; bit 0 releases first
//   ready    - high once every rst_out bit is released
//   phase    - 0 ASSERT, 1 SYNC, 2 STRETCH_REL, 3 RUN
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 8,
  parameter int N_OUT       = 3,
  parameter int GAP         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sw_req,
  output logic             rst_sync,
  output logic [N_OUT-1:0] rst_out,
  output logic             ready,
  output logic [1:0]       phase
);

  // The counter runs from the synchronizer release (or a sw_req) up to the
  // last staged release, then saturates.
  localparam int MAX_CNT = STRETCH + (N_OUT - 1) * GAP;
  localparam int CW      = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {
    ASSERT      = 2'd0,
    SYNC        = 2'd1,
    STRETCH_REL = 2'd2,
    RUN         = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt, cnt_inc;
  logic [N_OUT-1:0]       out_q, out_nxt;
  logic [SYNC_STAGES-1:0] sync_q;

  // Deassertion synchronizer. Zeros shift in only while reset is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

  // Bit i remains held while the count is below STRETCH + i*GAP.
  // Releases therefore follow index order.
  function automatic logic [N_OUT-1:0] held_mask(input logic [CW-1:0] c);
    logic [N_OUT-1:0] m;
    m = '1;
    for (int i = 0; i < N_OUT; i++) begin
      m[i] = (32'(c) < 32'(STRETCH + i * GAP));
    end
    return m;
  endfunction

  assign cnt_inc = cnt + CW'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = out_q;
    case (state)
      ASSERT: state_nxt = SYNC;
      SYNC: begin
        // rst_sync fell on the previous edge. Count that edge as zero so that
        // this edge is count 1.
        if (!rst_sync) begin
          cnt_nxt   = CW'(1);
          out_nxt   = held_mask(CW'(1));
          state_nxt = (MAX_CNT == 1) ? RUN : STRETCH_REL;
        end
      end
      STRETCH_REL, RUN: begin
        if (sw_req) begin
          cnt_nxt   = '0;
          out_nxt   = '1;
          state_nxt = STRETCH_REL;
        end else if (32'(cnt) < 32'(MAX_CNT)) begin
          cnt_nxt   = cnt_inc;
          out_nxt   = held_mask(cnt_inc);
          state_nxt = (32'(cnt_inc) == 32'(MAX_CNT)) ? RUN : STRETCH_REL;
        end
      end
      default: state_nxt = ASSERT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ASSERT;
      cnt   <= '0;
      out_q <= '1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      out_q <= out_nxt;
    end
  end

  assign rst_out = out_q;
  assign ready   = (state == RUN);
  assign phase   = state;

endmodule
